// File: rtl/conv_tile_sched.sv
// Tile scheduler for one conv layer: latches the layer configuration, then issues one
// re_fm_en per tile (tiles inner, oc-groups outer) and waits for each tile to complete.
module conv_tile_sched #(
  parameter int NIF_W  = 16,
  parameter int TILE_W = 16,
  parameter int OCG_W  = 8,
  parameter int TMO_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_mode,
  input  logic [NIF_W-1:0]  cfg_nif,
  input  logic [1:0]        cfg_k,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic [OCG_W-1:0]  cfg_num_ocg,
  input  logic              fm_ready,
  input  logic              quantify_add_end,
  output logic              re_fm_en,
  output logic [31:0]       nif_mult_k_mult_k,
  output logic              mode,
  output logic [TILE_W-1:0] tile_idx,
  output logic [OCG_W-1:0]  ocg_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_WAIT_FM, S_ISSUE, S_RUN, S_DONE
  } state_t;

  // Last watchdog value before saturation: the error fires on the 2^TMO_W-1'th RUN cycle.
  localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t              state;
  logic [NIF_W-1:0]    nif_q;
  logic                k3_q;
  logic [TILE_W-1:0]   tiles_q;
  logic [OCG_W-1:0]    ocgs_q;
  logic [TMO_W-1:0]    wdog;

  logic                cfg_ok;
  logic                last_tile;
  logic                last_ocg;
  logic [31:0]         nkk_calc;

  always_comb begin
    cfg_ok    = (cfg_nif != '0) && ((cfg_k == 2'd1) || (cfg_k == 2'd3)) &&
                (cfg_num_tiles != '0) && (cfg_num_ocg != '0);
    last_tile = (tile_idx == tiles_q - TILE_W'(1));
    last_ocg  = (ocg_idx == ocgs_q - OCG_W'(1));
    // k is 1 or 3 once latched, so k*k is 1 or 9.
    nkk_calc  = 32'(nif_q) * (k3_q ? 32'd9 : 32'd1) - 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      nif_q             <= '0;
      k3_q              <= 1'b0;
      tiles_q           <= '0;
      ocgs_q            <= '0;
      wdog              <= '0;
      re_fm_en          <= 1'b0;
      nif_mult_k_mult_k <= '0;
      mode              <= 1'b0;
      tile_idx          <= '0;
      ocg_idx           <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments; the pulse outputs default low here and are
      // raised only on the transition that owns them, which keeps each one a single cycle.
      re_fm_en <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                nif_q    <= cfg_nif;
                k3_q     <= (cfg_k == 2'd3);
                tiles_q  <= cfg_num_tiles;
                ocgs_q   <= cfg_num_ocg;
                mode     <= cfg_mode;
                tile_idx <= '0;
                ocg_idx  <= '0;
                busy     <= 1'b1;
                state    <= S_CALC;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_CALC: begin
            nif_mult_k_mult_k <= nkk_calc;
            state             <= S_WAIT_FM;
          end
          S_WAIT_FM: begin
            if (fm_ready) begin
              re_fm_en <= 1'b1;
              state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wdog  <= '0;
            state <= S_RUN;
          end
          S_RUN: begin
            // Completion is checked first so it wins over a simultaneous timeout.
            if (quantify_add_end) begin
              if (last_tile && last_ocg) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else if (last_tile) begin
                tile_idx <= '0;
                ocg_idx  <= ocg_idx + OCG_W'(1);
                state    <= S_WAIT_FM;
              end else begin
                tile_idx <= tile_idx + TILE_W'(1);
                state    <= S_WAIT_FM;
              end
            end else if (wdog == WDOG_LAST) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              wdog <= wdog + TMO_W'(1);
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched: a tile-order scoreboard checked on every re_fm_en/done,
// plus directed latency, illegal-config, watchdog, abort and reset scenarios.
`timescale 1ns/1ps
module tb_conv_tile_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, abort = 1'b0, cfg_mode = 1'b0;
  logic [15:0] cfg_nif = '0;
  logic [1:0]  cfg_k = '0;
  logic [15:0] cfg_num_tiles = '0;
  logic [7:0]  cfg_num_ocg = '0;
  logic        fm_ready = 1'b0, qae = 1'b0;

  logic        re_fm_en, mode, busy, done, err;
  logic [31:0] nif_mult_k_mult_k;
  logic [15:0] tile_idx;
  logic [7:0]  ocg_idx;

  logic        start2 = 1'b0, abort2 = 1'b0, qae2 = 1'b0;
  logic        t_re, t_mode, t_busy, t_done, t_err;
  logic [31:0] t_nkk;
  logic [15:0] t_tile;
  logic [7:0]  t_ocg;

  logic [60:0] all_out, t_all;
  assign all_out = {re_fm_en, nif_mult_k_mult_k, mode, tile_idx, ocg_idx, busy, done, err};
  assign t_all   = {t_re, t_nkk, t_mode, t_tile, t_ocg, t_busy, t_done, t_err};

  conv_tile_sched dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .cfg_nif(cfg_nif), .cfg_k(cfg_k), .cfg_num_tiles(cfg_num_tiles), .cfg_num_ocg(cfg_num_ocg),
    .fm_ready(fm_ready), .quantify_add_end(qae), .re_fm_en(re_fm_en),
    .nif_mult_k_mult_k(nif_mult_k_mult_k), .mode(mode), .tile_idx(tile_idx), .ocg_idx(ocg_idx),
    .busy(busy), .done(done), .err(err)
  );

  conv_tile_sched #(.TMO_W(4)) dut_t (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .cfg_mode(cfg_mode),
    .cfg_nif(cfg_nif), .cfg_k(cfg_k), .cfg_num_tiles(cfg_num_tiles), .cfg_num_ocg(cfg_num_ocg),
    .fm_ready(fm_ready), .quantify_add_end(qae2), .re_fm_en(t_re),
    .nif_mult_k_mult_k(t_nkk), .mode(t_mode), .tile_idx(t_tile), .ocg_idx(t_ocg),
    .busy(t_busy), .done(t_done), .err(t_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ocg; int tile; } pair_t;
  pair_t exp_q[$];
  pair_t p;
  int    exp_nkk;
  bit    exp_mode;
  int    n_tests = 0, n_fail = 0;
  int    re_cnt = 0, done_cnt = 0;
  bit    prev_re = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) @cycle %0d",
               name, act, act, want, want, cyc);
    end
  endtask

  // Scoreboard: every tile issue must be the next (ocg, tile) of the layer's nested loop.
  always @(negedge clk) begin
    if (reset) begin
      if (re_fm_en) begin
        check("re_fm_en single cycle", 64'(prev_re), 64'd0);
        check("busy during issue", 64'(busy), 64'd1);
        if (exp_q.size() == 0) begin
          check("re_fm_en with no tile pending", 64'(re_fm_en), 64'd0);
        end else begin
          p = exp_q.pop_front();
          check("issue ocg_idx", 64'(ocg_idx), 64'(p.ocg));
          check("issue tile_idx", 64'(tile_idx), 64'(p.tile));
          check("issue nif_mult_k_mult_k", 64'(nif_mult_k_mult_k), 64'(exp_nkk));
          check("issue mode", 64'(mode), 64'(exp_mode));
        end
      end
      if (done) check("done only after all tiles", 64'(exp_q.size()), 64'd0);
      if (done || err) check("done and err exclusive", 64'(done & err), 64'd0);
    end
    prev_re  <= re_fm_en;
    re_cnt   <= re_cnt + (re_fm_en ? 1 : 0);
    done_cnt <= done_cnt + (done ? 1 : 0);
  end

  task automatic set_cfg(input int nif, input int k, input int tiles, input int ocg, input bit md);
    cfg_nif       = 16'(nif);
    cfg_k         = 2'(k);
    cfg_num_tiles = 16'(tiles);
    cfg_num_ocg   = 8'(ocg);
    cfg_mode      = md;
  endtask

  task automatic start_layer(input int nif, input int k, input int tiles, input int ocg,
                             input bit md, output int s);
    set_cfg(nif, k, tiles, ocg, md);
    exp_q.delete();
    for (int o = 0; o < ocg; o++)
      for (int t = 0; t < tiles; t++) exp_q.push_back('{o, t});
    exp_nkk  = nif * k * k - 1;
    exp_mode = md;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_re(input bit rnd, output int at);
    int w = 0;
    while (!re_fm_en && w < 300) begin
      if (rnd) fm_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      w++;
    end
    check("re_fm_en within budget", 64'(re_fm_en), 64'd1);
    at = cyc;
  endtask

  task automatic pulse_qae(output int q);
    qae = 1'b1;
    q = cyc;
    @(negedge clk);
    qae = 1'b0;
  endtask

  task automatic run_layer(input int nif, input int k, input int tiles, input int ocg, input bit md,
                           input int dmin, input int dmax, input bit rnd, input bit chk_lat);
    int s, at, d;
    int q = 0;
    if (!rnd) fm_ready = 1'b1;
    start_layer(nif, k, tiles, ocg, md, s);
    for (int n = 0; n < tiles * ocg; n++) begin
      wait_re(rnd, at);
      if (chk_lat) begin
        if (n == 0) check("start->re_fm_en latency", 64'(at - s), 64'd3);
        else        check("qae->re_fm_en latency", 64'(at - q), 64'd2);
      end
      d = int'($urandom_range(dmax, dmin));
      repeat (d) @(negedge clk);
      pulse_qae(q);
    end
    check("done pulse", 64'(done), 64'd1);
    check("busy during done", 64'(busy), 64'd1);
    check("final tile_idx", 64'(tile_idx), 64'(tiles - 1));
    check("final ocg_idx", 64'(ocg_idx), 64'(ocg - 1));
    @(negedge clk);
    check("busy drops after done", 64'(busy), 64'd0);
    check("done single cycle", 64'(done), 64'd0);
  endtask

  task automatic illegal(input int nif, input int k, input int tiles, input int ocg);
    int r0 = re_cnt;
    set_cfg(nif, k, tiles, ocg, 1'b1);
    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("illegal cfg err pulse", 64'(err), 64'd1);
    check("illegal cfg busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("illegal cfg err single cycle", 64'(err), 64'd0);
    repeat (4) @(negedge clk);
    check("illegal cfg stays idle", 64'(busy), 64'd0);
    check("illegal cfg no re_fm_en", 64'(re_cnt - r0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int s, at, q, f, r0, r1, d0, ec, dn;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("outputs in reset", 64'(all_out), 64'd0);
    check("timeout dut outputs in reset", 64'(t_all), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("outputs after reset release", 64'(all_out), 64'd0);

    // Nominal layer: 2 oc-groups x 2 tiles, tile completes 40 cycles after issue.
    r0 = re_cnt; d0 = done_cnt;
    run_layer(4, 3, 2, 2, 1'b1, 40, 40, 1'b0, 1'b1);
    check("nominal re_fm_en count", 64'(re_cnt - r0), 64'd4);
    check("nominal done count", 64'(done_cnt - d0), 64'd1);
    check("nominal nif*k*k-1", 64'(nif_mult_k_mult_k), 64'd35);
    check("nominal mode", 64'(mode), 64'd1);

    illegal(3, 2, 1, 1);
    illegal(0, 3, 1, 1);
    illegal(5, 0, 1, 1);
    illegal(5, 1, 0, 1);
    illegal(5, 3, 2, 0);

    // Feature map not ready for 10 cycles after CALC.
    fm_ready = 1'b0;
    r0 = re_cnt;
    start_layer(3, 1, 1, 1, 1'b0, s);
    repeat (10) @(negedge clk);
    check("no issue while fm not ready", 64'(re_cnt - r0), 64'd0);
    check("busy while waiting fm", 64'(busy), 64'd1);
    fm_ready = 1'b1;
    f = cyc;
    @(negedge clk);
    check("re_fm_en one cycle after fm_ready", 64'(re_fm_en), 64'd1);
    check("fm wait issue cycle", 64'(cyc - f), 64'd1);
    repeat (2) @(negedge clk);
    pulse_qae(q);
    check("fm wait layer done", 64'(done), 64'd1);
    check("nif=3 k=1 product", 64'(nif_mult_k_mult_k), 64'd2);
    @(negedge clk);

    // Watchdog on the TMO_W=4 instance: no completion ever arrives.
    set_cfg(1, 1, 1, 1, 1'b0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    dn = 0;
    while (!t_re && dn < 20) begin @(negedge clk); dn++; end
    check("watchdog dut issue", 64'(t_re), 64'd1);
    at = cyc; ec = -1; dn = 0;
    for (int i = 0; i < 40 && ec < 0; i++) begin
      @(negedge clk);
      if (t_done) dn++;
      if (t_err) begin
        ec = cyc;
        check("busy low with timeout err", 64'(t_busy), 64'd0);
      end
    end
    check("timeout after 15 RUN cycles", 64'(ec - (at + 1)), 64'd15);
    check("no done on timeout", 64'(dn), 64'd0);
    @(negedge clk);
    check("timeout err single cycle", 64'(t_err), 64'd0);
    check("idle after timeout", 64'(t_busy), 64'd0);

    // Completion in the saturation cycle beats the timeout.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    dn = 0;
    while (!t_re && dn < 20) begin @(negedge clk); dn++; end
    at = cyc;
    repeat (15) @(negedge clk);
    check("still running on last RUN cycle", 64'(t_busy), 64'd1);
    qae2 = 1'b1;
    @(negedge clk);
    qae2 = 1'b0;
    check("completion wins over timeout: done", 64'(t_done), 64'd1);
    check("completion wins over timeout: err", 64'(t_err), 64'd0);
    @(negedge clk);

    // Abort during RUN of tile 1.
    fm_ready = 1'b1;
    d0 = done_cnt;
    start_layer(2, 1, 3, 1, 1'b0, s);
    wait_re(1'b0, at);
    repeat (3) @(negedge clk);
    pulse_qae(q);
    wait_re(1'b0, at);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort no pulses", 64'({re_fm_en, done, err}), 64'd0);
    check("abort holds tile_idx", 64'(tile_idx), 64'd1);
    check("abort holds ocg_idx", 64'(ocg_idx), 64'd0);
    check("abort holds product", 64'(nif_mult_k_mult_k), 64'd1);
    exp_q.delete();
    r1 = re_cnt;
    @(negedge clk);
    pulse_qae(q);
    repeat (8) @(negedge clk);
    check("late qae ignored: busy", 64'(busy), 64'd0);
    check("late qae ignored: no issue", 64'(re_cnt - r1), 64'd0);
    check("abort never signals done", 64'(done_cnt - d0), 64'd0);
    run_layer(5, 3, 2, 3, 1'b1, 1, 5, 1'b0, 1'b1);
    check("layer after abort product", 64'(nif_mult_k_mult_k), 64'd44);

    // Extra start while busy, then async reset mid-RUN.
    start_layer(6, 1, 2, 2, 1'b1, s);
    wait_re(1'b0, at);
    repeat (2) @(negedge clk);
    set_cfg(7, 2, 9, 9, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start while busy: no err", 64'(err), 64'd0);
    check("start while busy: still busy", 64'(busy), 64'd1);
    check("start while busy: mode kept", 64'(mode), 64'd1);
    check("start while busy: product kept", 64'(nif_mult_k_mult_k), 64'd5);
    pulse_qae(q);
    wait_re(1'b0, at);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async reset clears outputs at once", 64'(all_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("outputs stay clear after reset", 64'(all_out), 64'd0);

    // Largest input-channel count with k=3.
    run_layer(65535, 3, 1, 1, 1'b0, 1, 3, 1'b0, 1'b1);
    check("max nif product", 64'(nif_mult_k_mult_k), 64'd589814);

    // Randomized layers with a flickering fm_ready.
    for (int i = 0; i < 8; i++) begin
      run_layer(int'($urandom_range(40, 1)), ($urandom_range(1, 0) != 0) ? 3 : 1,
                int'($urandom_range(3, 1)), int'($urandom_range(3, 1)),
                1'($urandom_range(1, 0)), 1, 6, 1'b1, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
